// File: rtl/quad_decoder_multi.sv
// Quadrature decoder: synchronises and glitch-filters A/B/Z, decodes 1x/2x/4x, keeps a position count.
// Latency: pin edge -> counter/step/dir update in SYNC_STAGES+FILTER_LEN+1 clk cycles.
// Backpressure: none; free-running pin sampler, outputs are level/pulse registers with no handshake.
module quad_decoder_multi #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int WRAP        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 A_channel,
    input  logic                 B_channel,
    input  logic                 Z_channel,
    input  logic [1:0]           mode,
    input  logic                 idx_clr_en,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] preset,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 dir,
    output logic                 step,
    output logic                 idx_pulse,
    output logic                 ovf,
    output logic                 unf,
    output logic                 err
);

    // Pin indices inside the per-pin arrays.
    localparam int PIN_A = 0;
    localparam int PIN_B = 1;
    localparam int PIN_Z = 2;

    // Run-length counter must hold values up to FILTER_LEN-1.
    localparam int RUN_W    = $clog2(FILTER_LEN + 1);
    // Warm-up lasts long enough to flush the synchronisers and one filter window.
    localparam int WARM_CYC = SYNC_STAGES + FILTER_LEN;
    localparam int WARM_W   = $clog2(WARM_CYC + 1);

    localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(FILTER_LEN - 1);
    localparam logic [WARM_W-1:0]    WARM_END = WARM_W'(WARM_CYC);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [2:0]             pin_raw;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [RUN_W-1:0]       run_q  [3];
    logic [2:0]             synced;
    logic [2:0]             filt_q;
    logic [2:0]             prev_q;

    logic [WARM_W-1:0]      warm_cnt;
    logic                   warm;

    logic                   ch_a;
    logic                   ch_b;
    logic                   fwd;
    logic                   illegal;
    logic                   cand;
    logic                   qual;
    logic                   z_rise;
    logic                   idx_clr;
    logic                   at_max;
    logic                   at_zero;

    assign pin_raw = {Z_channel, B_channel, A_channel};

    // Last synchroniser stage of each pin is the value the filter works on.
    always_comb begin
        synced = '0;
        for (int i = 0; i < 3; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Warm-up counter: runs from reset release until the pipeline holds real pin data.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (warm) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    assign warm = (warm_cnt != WARM_END);

    // Synchroniser chains, one shift register per pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pin_raw[i]};
            end
        end
    end

    // Glitch filter: accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                run_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (warm) begin
                    // During warm-up the filter tracks the synchronised level directly,
                    // so the first decode cycle starts from the settled pin state.
                    filt_q[i] <= synced[i];
                    run_q[i]  <= '0;
                end else if (synced[i] != filt_q[i]) begin
                    if (run_q[i] == RUN_LAST) begin
                        filt_q[i] <= synced[i];
                        run_q[i]  <= '0;
                    end else begin
                        run_q[i] <= run_q[i] + RUN_W'(1);
                    end
                end else begin
                    // Any return to the accepted level restarts the run.
                    run_q[i] <= '0;
                end
            end
        end
    end

    // Previous filtered levels, the reference for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= filt_q;
        end
    end

    // Edge classification. Forward means A leads B: new A differs from old B.
    assign ch_a    = filt_q[PIN_A] ^ prev_q[PIN_A];
    assign ch_b    = filt_q[PIN_B] ^ prev_q[PIN_B];
    assign fwd     = filt_q[PIN_A] ^ prev_q[PIN_B];
    assign illegal = ~warm & ch_a & ch_b;
    assign cand    = ~warm & (ch_a ^ ch_b);
    assign z_rise  = ~warm & filt_q[PIN_Z] & ~prev_q[PIN_Z];
    assign idx_clr = idx_clr_en & z_rise;
    assign at_max  = (counter == CNT_MAX);
    assign at_zero = (counter == '0);

    // Mode qualification: 4x takes every edge, 2x only A edges, 1x only A edges while B is low.
    always_comb begin
        qual = 1'b0;
        case (mode)
            2'b00:   qual = cand & ch_a & ~filt_q[PIN_B];
            2'b01:   qual = cand & ch_a;
            default: qual = cand;
        endcase
    end

    // Position counter with load > index clear > step priority, plus step/dir/ovf/unf pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            idx_pulse <= 1'b0;
        end else begin
            step      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            // The index pulse reports the Z edge even when the clear itself loses to load.
            idx_pulse <= z_rise;
            if (load) begin
                counter <= preset;
            end else if (idx_clr) begin
                counter <= '0;
            end else if (qual) begin
                step <= 1'b1;
                dir  <= fwd;
                if (fwd) begin
                    if (at_max) begin
                        ovf     <= 1'b1;
                        counter <= (WRAP != 0) ? '0 : counter;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end else begin
                    if (at_zero) begin
                        unf     <= 1'b1;
                        counter <= (WRAP != 0) ? CNT_MAX : counter;
                    end else begin
                        counter <= counter - CNT_ONE;
                    end
                end
            end
        end
    end

    // Sticky illegal-transition flag; a new illegal event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (illegal) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Directed bench for quad_decoder_multi: main 16-bit wrapping instance plus 8-bit wrap/saturate instances.
// Latency: checks assume 2 sync stages and a 4-cycle filter (7 clk from pin edge to count).
// Backpressure: none; stimulus is driven just after the falling edge, outputs read there too.
module tb_quad_decoder_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic        z = 1'b0;
    logic [1:0]  mode = 2'b10;
    logic        idx_clr_en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = 16'd0;
    logic        err_clr = 1'b0;

    logic [15:0] cnt;
    logic        dir, step, idx, ovf, unf, err;
    logic [7:0]  cnt_w, cnt_s;
    logic        dir_w, step_w, idx_w, ovf_w, unf_w, err_w;
    logic        dir_s, step_s, idx_s, ovf_s, unf_s, err_s;

    int vectors = 0;
    int miscompares = 0;
    int step_cnt = 0;
    int snap;

    always #5 clk = ~clk;

    quad_decoder_multi #(.CNT_WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(4), .WRAP(1)) u_main (
        .clk(clk), .rst(rst), .A_channel(a), .B_channel(b), .Z_channel(z), .mode(mode),
        .idx_clr_en(idx_clr_en), .load(load), .preset(preset), .err_clr(err_clr),
        .counter(cnt), .dir(dir), .step(step), .idx_pulse(idx), .ovf(ovf), .unf(unf), .err(err));

    quad_decoder_multi #(.CNT_WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .WRAP(1)) u_wrap8 (
        .clk(clk), .rst(rst), .A_channel(a), .B_channel(b), .Z_channel(z), .mode(mode),
        .idx_clr_en(idx_clr_en), .load(load), .preset(preset[7:0]), .err_clr(err_clr),
        .counter(cnt_w), .dir(dir_w), .step(step_w), .idx_pulse(idx_w), .ovf(ovf_w), .unf(unf_w), .err(err_w));

    quad_decoder_multi #(.CNT_WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .WRAP(0)) u_sat8 (
        .clk(clk), .rst(rst), .A_channel(a), .B_channel(b), .Z_channel(z), .mode(mode),
        .idx_clr_en(idx_clr_en), .load(load), .preset(preset[7:0]), .err_clr(err_clr),
        .counter(cnt_s), .dir(dir_s), .step(step_s), .idx_pulse(idx_s), .ovf(ovf_s), .unf(unf_s), .err(err_s));

    // Count main-instance step pulses on the falling edge, well away from the update edge.
    always @(negedge clk) begin
        if (step) step_cnt++;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // n full quadrature cycles, 8 clk per phase; forward = A leads B.
    task automatic quad(input bit fwd_dir, input int n);
        for (int i = 0; i < n; i++) begin
            if (fwd_dir) begin
                a = 1'b1; w(8); b = 1'b1; w(8); a = 1'b0; w(8); b = 1'b0; w(8);
            end else begin
                b = 1'b1; w(8); a = 1'b1; w(8); b = 1'b0; w(8); a = 1'b0; w(8);
            end
        end
    endtask

    task automatic pulse_load(input logic [15:0] val);
        preset = val; load = 1'b1; w(1); load = 1'b0;
    endtask

    initial begin
        // Reset state
        w(3);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        w(10);

        // 4x forward then reverse
        mode = 2'b10;
        snap = step_cnt;
        quad(1'b1, 10);
        chk("x4_fwd_cnt", 32'(cnt), 32'd40);
        chk("x4_fwd_dir", 32'(dir), 32'd1);
        chk("x4_fwd_steps", 32'(step_cnt - snap), 32'd40);
        quad(1'b0, 10);
        chk("x4_rev_cnt", 32'(cnt), 32'd0);
        chk("x4_rev_dir", 32'(dir), 32'd0);
        chk("x4_rev_steps", 32'(step_cnt - snap), 32'd80);

        // Latency of a single A edge, then a 3-clk glitch
        a = 1'b1;
        w(6);
        chk("lat_before", 32'(cnt), 32'd0);
        w(1);
        chk("lat_cnt", 32'(cnt), 32'd1);
        chk("lat_step", 32'(step), 32'd1);
        chk("lat_dir", 32'(dir), 32'd1);
        w(8);
        a = 1'b0;
        w(8);
        chk("lat_back", 32'(cnt), 32'd0);
        snap = step_cnt;
        a = 1'b1; w(3); a = 1'b0;
        w(15);
        chk("glitch_cnt", 32'(cnt), 32'd0);
        chk("glitch_steps", 32'(step_cnt - snap), 32'd0);

        // 2x and 1x modes
        mode = 2'b01; quad(1'b1, 10);
        chk("x2_fwd_cnt", 32'(cnt), 32'd20);
        mode = 2'b00; quad(1'b1, 10);
        chk("x1_fwd_cnt", 32'(cnt), 32'd30);
        quad(1'b0, 10);
        chk("x1_rev_cnt", 32'(cnt), 32'd20);
        mode = 2'b01; quad(1'b0, 10);
        chk("x2_rev_cnt", 32'(cnt), 32'd0);

        // Boundaries: 8-bit wrap and saturate instances
        mode = 2'b10;
        pulse_load(16'd255);
        chk("load_w8", 32'(cnt_w), 32'd255);
        chk("load_main", 32'(cnt), 32'd255);
        a = 1'b1;
        w(7);
        chk("wrap_up_cnt", 32'(cnt_w), 32'd0);
        chk("wrap_up_ovf", 32'(ovf_w), 32'd1);
        chk("sat_up_cnt", 32'(cnt_s), 32'd255);
        chk("sat_up_ovf", 32'(ovf_s), 32'd1);
        chk("sat_up_step", 32'(step_s), 32'd1);
        chk("main_256", 32'(cnt), 32'd256);
        chk("main_no_ovf", 32'(ovf), 32'd0);
        w(1);
        chk("wrap_ovf_end", 32'(ovf_w), 32'd0);
        w(7);
        pulse_load(16'd0);
        a = 1'b0;
        w(7);
        chk("sat_dn_cnt", 32'(cnt_s), 32'd0);
        chk("sat_dn_unf", 32'(unf_s), 32'd1);
        chk("wrap_dn_cnt", 32'(cnt_w), 32'd255);
        chk("wrap_dn_unf", 32'(unf_w), 32'd1);
        chk("main_dn_cnt", 32'(cnt), 32'h0000FFFF);
        chk("main_dn_unf", 32'(unf), 32'd1);
        chk("main_dn_dir", 32'(dir), 32'd0);
        w(4);

        // Illegal transitions and sticky err
        pulse_load(16'd100);
        a = 1'b1; b = 1'b1;
        w(7);
        chk("err_set", 32'(err), 32'd1);
        chk("err_cnt", 32'(cnt), 32'd100);
        chk("err_nostep", 32'(step), 32'd0);
        err_clr = 1'b1; w(1); err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'd0);
        w(6);
        a = 1'b0; b = 1'b0;
        w(6);
        err_clr = 1'b1; w(1); err_clr = 1'b0;
        chk("err_clr_vs_new", 32'(err), 32'd1);
        err_clr = 1'b1; w(1); err_clr = 1'b0;
        chk("err_clr2", 32'(err), 32'd0);
        w(4);

        // Index clear beats a same-cycle step; load beats index clear
        idx_clr_en = 1'b1;
        pulse_load(16'd37);
        chk("idx_pre", 32'(cnt), 32'd37);
        z = 1'b1; a = 1'b1;
        w(7);
        chk("idx_clr_cnt", 32'(cnt), 32'd0);
        chk("idx_pulse", 32'(idx), 32'd1);
        chk("idx_nostep", 32'(step), 32'd0);
        w(1);
        chk("idx_pulse_end", 32'(idx), 32'd0);
        z = 1'b0;
        w(8);
        z = 1'b1;
        w(6);
        pulse_load(16'd1234);
        chk("load_vs_idx_cnt", 32'(cnt), 32'd1234);
        chk("load_vs_idx_pulse", 32'(idx), 32'd1);

        // Reset mid-motion and warm-up
        z = 1'b0;
        w(8);
        b = 1'b1;
        w(3);
        rst = 1'b1;
        w(1);
        chk("mrst_cnt", 32'(cnt), 32'd0);
        chk("mrst_dir", 32'(dir), 32'd0);
        chk("mrst_idx", 32'(idx), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        w(2);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            w(1);
            chk("warm_cnt", 32'(cnt), 32'd0);
            chk("warm_step", 32'(step), 32'd0);
        end
        a = 1'b0;
        w(7);
        chk("post_warm_cnt", 32'(cnt), 32'd1);
        chk("post_warm_dir", 32'(dir), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
